dsp_mem_loader: RTL
===================

Name: dsp_mem_loader

Overview:
- Host-side producer for the per-core DSP memory write port (proc_write_sel / mem_write_sel / mem_write_addr / mem_write_data / mem_write_en).
- Accepts a packetised 32-bit AXI-Stream from the config/DMA path and decodes each packet into a burst of single-cycle memory writes.
- Targets command, envelope and frequency memories of any processor core.
- Validates headers and packet framing, and reports errors and status to the config register block.

Parameters:
- DATAWIDTH, 32, stream word width and mem_write_data width.
- ADDRWIDTH, 16, mem_write_addr width.
- NPROC, 4, number of processor cores; proc_sel ≥ NPROC is illegal.
- NMEMSEL, 3, number of legal mem_sel codes (0 cmd, 1 env, 2 freq); mem_sel ≥ NMEMSEL is illegal.
- SELWIDTH, 3, width of proc_write_sel and mem_write_sel.

Ports:
- clk  in  1  DSP clock.
- resetn  in  1  asynchronous active-low reset.
- s_tdata  in  DATAWIDTH  stream word.
- s_tvalid  in  1  word valid.
- s_tlast  in  1  last word of packet.
- s_tready  out  1  loader ready.
- mem_write_data  out  DATAWIDTH  write data.
- mem_write_addr  out  ADDRWIDTH  write address.
- proc_write_sel  out  SELWIDTH  target core.
- mem_write_sel  out  SELWIDTH  target memory.
- mem_write_en  out  1  one-cycle write strobe.
- busy  out  1  high while inside a packet.
- err  out  1  sticky error flag.
- err_code  out  3  code of the first error since the last clear.
- err_clr  in  1  clears err and err_code.
- pkt_count  out  16  number of packets completed cleanly; wraps.

Behaviour:
- Packet format:
  - H0: [31:29] proc_sel, [28:26] mem_sel, [15:0] base address.
  - H1: [15:0] len_m1; word count = len_m1 + 1, range 1..65536.
  - Then exactly len_m1 + 1 data words; tlast is on the last data word.
- Beat accepted when s_tvalid & s_tready.
- s_tready: 0 while resetn is low; 1 from the first clk edge after reset release. The loader never back-pressures.
- FSM states:
  - HDR0 → HDR1 on an accepted H0 without tlast.
  - HDR1 → DATA on an accepted H1 without tlast.
  - DATA → HDR0 on the final word with tlast.
  - DRAIN → HDR0 on an accepted tlast.
- Write timing:
  - Each data beat accepted in DATA produces mem_write_en = 1 on the following cycle (latency 1, registered outputs).
  - On that cycle: addr = base + index mod 2^ADDRWIDTH (wrap-around permitted, not an error); data = the beat; sel outputs = the latched header values.
- Error codes (only the first is latched; err stays set until err_clr):
  - 1: illegal proc_sel or mem_sel in H0 → DRAIN, no writes for that packet.
  - 2: tlast on H0 or H1 → HDR0, no writes.
  - 3: tlast before the final data word → write that word, then HDR0.
  - 4: final data word without tlast → write it, then DRAIN.
  - 5: checksum mismatch (see Optional Feature).
- Counters and status:
  - pkt_count increments only on a clean packet end.
  - busy = (state != HDR0).
- err_clr arriving in the same cycle as a new error: the new error wins.
- Reset (asynchronous, any time including mid-packet):
  - state HDR0; all outputs 0; pkt_count 0; err 0.
  - A partially written packet is abandoned; the host must resend it.
- Beats with s_tvalid low are ignored; the state holds.

Optional Feature:
- Macro: DSP_MEM_LOADER_CKSUM_EN.
- When defined:
  - Each packet carries one extra trailing word after the data words; tlast moves to this word.
  - The trailing word must equal the XOR of H0, H1 and all data words.
  - A mismatch sets error code 5; the writes have already occurred.
  - The trailing word is never written to memory.
  - Adds FSM state CKSUM between DATA and HDR0.
- When undefined: no trailing word and no CKSUM state.

Decomposition:
- Package dsp_mem_loader_pkg holds:
  - state enum: HDR0, HDR1, DATA, DRAIN, CKSUM.
  - err_code enum: NONE, BADSEL, SHORTHDR, EARLYLAST, NOLAST, CKSUM.
  - header field bit positions.
  - memory select constants: MEMSEL_CMD = 0, MEMSEL_ENV = 1, MEMSEL_FREQ = 2.
- No sub-module; a single module is sufficient.

Test Plan:
- Clean packet:
  - Stimulus: H0 = proc 1, mem 0, base 0x0010; H1 len_m1 = 3; data 0xA0..0xA3.
  - Response: 4 strobes at addr 0x10..0x13, proc_write_sel = 1, mem_write_sel = 0, each one cycle after its beat; pkt_count = 1; err = 0.
- Address wrap and gappy s_tvalid:
  - Stimulus: base 0xFFFE, 4 words, s_tvalid toggling.
  - Response: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; no strobe on idle cycles.
- Illegal select:
  - Stimulus: proc_sel = 5, 2-word packet, followed by a clean packet.
  - Response: err = 1, err_code = 1, no writes for the bad packet; the next packet writes correctly.
- Framing errors:
  - Stimulus: tlast on H1; then a packet with len 4 and tlast on word 2; then len 2 without tlast plus 2 junk words ending in tlast.
  - Response: err_code = 2 latched; writes are 2 words then 2 words; junk is drained.
- Reset mid-packet:
  - Stimulus: resetn low after 2 of 8 data words.
  - Response: outputs 0 immediately (asynchronous); state HDR0; a resent packet completes with pkt_count = 1.
- Checksum (macro on):
  - Stimulus: correct trailing word, then a wrong trailing word.
  - Response: first packet clean; second sets err_code = 5; trailing words are never strobed.

Source files
------------

// File: rtl/dsp_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mem_loader_pkg
// Shared definitions for the DSP memory loader: FSM state and error code
// encodings, header field bit positions, memory select codes and a helper
// that checks whether a header targets an existing core and memory.
// -----------------------------------------------------------------------------
package dsp_mem_loader_pkg;

  // FSM states. ST_CKSUM is only reachable when DSP_MEM_LOADER_CKSUM_EN is set.
  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CKSUM = 3'd4
  } state_e;

  // Error codes reported on err_code (only the first one since a clear is kept).
  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BADSEL    = 3'd1,
    ERR_SHORTHDR  = 3'd2,
    ERR_EARLYLAST = 3'd3,
    ERR_NOLAST    = 3'd4,
    ERR_CKSUM     = 3'd5
  } err_code_e;

  // Header word 0 fields
  localparam int H0_PROC_MSB = 31;
  localparam int H0_PROC_LSB = 29;
  localparam int H0_MEM_MSB  = 28;
  localparam int H0_MEM_LSB  = 26;
  localparam int H0_BASE_MSB = 15;
  localparam int H0_BASE_LSB = 0;

  // Header word 1 fields
  localparam int H1_LEN_MSB  = 15;
  localparam int H1_LEN_LSB  = 0;

  // Memory select codes
  localparam logic [2:0] MEMSEL_CMD  = 3'd0;
  localparam logic [2:0] MEMSEL_ENV  = 3'd1;
  localparam logic [2:0] MEMSEL_FREQ = 3'd2;

  // True when the header names an existing core and an existing memory.
  function automatic logic sel_legal(input logic [2:0] proc, input logic [2:0] mem,
                                     input int nproc, input int nmemsel);
    return (int'(proc) < nproc) && (int'(mem) < nmemsel);
  endfunction

endpackage

// File: rtl/dsp_mem_loader.sv
// -----------------------------------------------------------------------------
// dsp_mem_loader
// Decodes a packetised AXI-Stream (H0, H1, data words) into single-cycle
// writes on the per-core DSP memory write port, validating headers and
// framing and reporting a sticky first-error code plus a clean-packet count.
//
// Optional feature: define DSP_MEM_LOADER_CKSUM_EN to require one trailing
// checksum word per packet (XOR of H0, H1 and all data words). The trailing
// word carries tlast, is never written, and a mismatch reports error code 5.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tlast    input stream word, valid, end of packet
//   s_tready                    loader ready (1 from first edge after reset)
//   mem_write_data/addr         write data and address (registered)
//   proc_write_sel/mem_write_sel target core and memory of the write
//   mem_write_en                one-cycle write strobe
//   busy                        high while inside a packet
//   err, err_code, err_clr      sticky error flag, first error code, clear
//   pkt_count                   packets completed cleanly (wraps)
//   dbg_state                   current FSM state (state_e encoding)
//
// Handshake: a beat transfers on a rising edge where s_tvalid and s_tready
// are both high; s_tready never drops after reset, so the source alone paces
// the stream and cycles with s_tvalid low leave all state untouched.
// -----------------------------------------------------------------------------
module dsp_mem_loader
  import dsp_mem_loader_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 16,
  parameter int NPROC     = 4,
  parameter int NMEMSEL   = 3,
  parameter int SELWIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DATAWIDTH-1:0] s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  output logic                 s_tready,
  output logic [DATAWIDTH-1:0] mem_write_data,
  output logic [ADDRWIDTH-1:0] mem_write_addr,
  output logic [SELWIDTH-1:0]  proc_write_sel,
  output logic [SELWIDTH-1:0]  mem_write_sel,
  output logic                 mem_write_en,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           err_code,
  input  logic                 err_clr,
  output logic [15:0]          pkt_count,
  output logic [2:0]           dbg_state
);

  logic [2:0]           r_state;
  logic                 r_ready;
  logic [SELWIDTH-1:0]  r_proc;
  logic [SELWIDTH-1:0]  r_mem;
  logic [ADDRWIDTH-1:0] r_base;
  logic [15:0]          r_len_m1;
  logic [15:0]          r_idx;
  logic                 r_wen;
  logic [DATAWIDTH-1:0] r_wdata;
  logic [ADDRWIDTH-1:0] r_waddr;
  logic [SELWIDTH-1:0]  r_wproc;
  logic [SELWIDTH-1:0]  r_wmem;
  logic                 r_err;
  logic [2:0]           r_err_code;
  logic [15:0]          r_pkt_count;
`ifdef DSP_MEM_LOADER_CKSUM_EN
  logic [DATAWIDTH-1:0] r_xor;
`endif

  logic       w_beat;
  logic       w_final;
  logic       w_legal;
  logic       w_wr;
  logic       w_pkt_done;
  logic [2:0] w_err_new;
  logic [2:0] w_state_nxt;

  assign w_beat  = s_tvalid & r_ready;
  assign w_final = (r_idx == r_len_m1);
  assign w_legal = sel_legal(s_tdata[H0_PROC_MSB:H0_PROC_LSB],
                             s_tdata[H0_MEM_MSB:H0_MEM_LSB], NPROC, NMEMSEL);

  always_comb begin
    w_state_nxt = r_state;
    w_err_new   = ERR_NONE;
    w_wr        = 1'b0;
    w_pkt_done  = 1'b0;
    if (w_beat) begin
      case (r_state)
        ST_HDR0: begin
          if (s_tlast) begin
            w_err_new = ERR_SHORTHDR;
          end else if (!w_legal) begin
            // Swallow the rest of the packet without writing anything.
            w_err_new   = ERR_BADSEL;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (s_tlast) begin
            w_err_new   = ERR_SHORTHDR;
            w_state_nxt = ST_HDR0;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          // Every data beat is written, even the one that reveals a framing error.
          w_wr = 1'b1;
          if (s_tlast) begin
            w_state_nxt = ST_HDR0;
`ifdef DSP_MEM_LOADER_CKSUM_EN
            // tlast belongs on the checksum word, so any tlast here is early.
            w_err_new = ERR_EARLYLAST;
`else
            if (w_final) w_pkt_done = 1'b1;
            else         w_err_new  = ERR_EARLYLAST;
`endif
          end else if (w_final) begin
`ifdef DSP_MEM_LOADER_CKSUM_EN
            w_state_nxt = ST_CKSUM;
`else
            w_err_new   = ERR_NOLAST;
            w_state_nxt = ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          if (s_tlast) w_state_nxt = ST_HDR0;
        end
`ifdef DSP_MEM_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (s_tlast) begin
            w_state_nxt = ST_HDR0;
            if (s_tdata == r_xor) w_pkt_done = 1'b1;
            else                  w_err_new  = ERR_CKSUM;
          end else begin
            w_err_new   = ERR_NOLAST;
            w_state_nxt = ST_DRAIN;
          end
        end
`endif
        default: w_state_nxt = ST_HDR0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_HDR0;
      r_ready     <= 1'b0;
      r_proc      <= '0;
      r_mem       <= '0;
      r_base      <= '0;
      r_len_m1    <= '0;
      r_idx       <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_waddr     <= '0;
      r_wproc     <= '0;
      r_wmem      <= '0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_pkt_count <= '0;
`ifdef DSP_MEM_LOADER_CKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_ready <= 1'b1;
      r_state <= w_state_nxt;
      r_wen   <= w_wr;

      if (w_wr) begin
        r_wdata <= s_tdata;
        r_waddr <= r_base + ADDRWIDTH'(r_idx);  // wraps modulo 2^ADDRWIDTH
        r_wproc <= r_proc;
        r_wmem  <= r_mem;
        r_idx   <= r_idx + 16'd1;
      end

      if (w_beat && (r_state == ST_HDR0)) begin
        r_proc <= SELWIDTH'(s_tdata[H0_PROC_MSB:H0_PROC_LSB]);
        r_mem  <= SELWIDTH'(s_tdata[H0_MEM_MSB:H0_MEM_LSB]);
        r_base <= ADDRWIDTH'(s_tdata[H0_BASE_MSB:H0_BASE_LSB]);
      end

      if (w_beat && (r_state == ST_HDR1)) begin
        r_len_m1 <= s_tdata[H1_LEN_MSB:H1_LEN_LSB];
        r_idx    <= '0;
      end

`ifdef DSP_MEM_LOADER_CKSUM_EN
      if (w_beat) begin
        if (r_state == ST_HDR0) r_xor <= s_tdata;
        else                    r_xor <= r_xor ^ s_tdata;
      end
`endif

      // First error is kept; a new error in the same cycle as err_clr wins.
      if (w_err_new != ERR_NONE) begin
        if (!r_err || err_clr) begin
          r_err      <= 1'b1;
          r_err_code <= w_err_new;
        end
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end

      if (w_pkt_done) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign s_tready       = r_ready;
  assign mem_write_data = r_wdata;
  assign mem_write_addr = r_waddr;
  assign proc_write_sel = r_wproc;
  assign mem_write_sel  = r_wmem;
  assign mem_write_en   = r_wen;
  assign busy           = (r_state != ST_HDR0);
  assign err            = r_err;
  assign err_code       = r_err_code;
  assign pkt_count      = r_pkt_count;
  assign dbg_state      = r_state;

endmodule
